// File: rtl/ae350_dvs_ctrl.sv
// ae350_dvs_ctrl: shared-ramp dynamic voltage scaling controller for NUM_PD power-domain channels
module ae350_dvs_ctrl #(
    parameter int                NUM_PD     = 7,
    parameter int                VS_W       = 3,
    parameter int                RST_VS     = 4,
    parameter int                STEP_CYC   = 4,
    parameter int                SETTLE_CYC = 8,
    parameter logic [NUM_PD-1:0] AON_MASK   = 'b1
) (
    input  logic                   aopd_clk_32k,
    input  logic                   aopd_rtc_rstn,
    input  logic [NUM_PD-1:0]      pcs_vol_scale_req,
    input  logic [NUM_PD*VS_W-1:0] pcs_vol_scale,
    input  logic [NUM_PD-1:0]      voltage_unstable,
    output logic [NUM_PD-1:0]      pcs_vol_scale_ack,
    output logic [NUM_PD-1:0]      pd_vol_on,
    output logic [NUM_PD*VS_W-1:0] pd_vol_level,
    output logic                   dvs_busy
);
    localparam int PW = NUM_PD > 1 ? $clog2(NUM_PD) : 1;
    localparam int SW = STEP_CYC > 1 ? $clog2(STEP_CYC) : 1;
    localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RAMP, SETTLE, ACK} state_e;

    state_e                       st_q;
    logic [NUM_PD-1:0]            req_m_q, req_s_q, ack_q, on_q;
    logic [NUM_PD-1:0][VS_W-1:0]  lvl_q;
    logic [PW-1:0]                rr_q, ch_q, gnt;
    logic [VS_W-1:0]              tgt_q, tgt_g, lvl_nxt;
    logic [SW-1:0]                step_q;
    logic [CW-1:0]                set_q;
    logic [NUM_PD-1:0]            pend;

    assign pcs_vol_scale_ack = ack_q;
    assign pd_vol_on         = on_q;
    assign pd_vol_level      = lvl_q;
    assign dvs_busy          = st_q != IDLE;

    // Two-flop synchroniser bringing requests into the always-on clock domain
    always_ff @(posedge aopd_clk_32k or negedge aopd_rtc_rstn) begin
        if (!aopd_rtc_rstn) begin
            req_m_q <= '0;
            req_s_q <= '0;
        end else begin
            req_m_q <= pcs_vol_scale_req;
            req_s_q <= req_m_q;
        end
    end

    // Round-robin pick: first pending channel at or after rr_q, wrapping; also the one-LSB step toward target
    always_comb begin
        pend = req_s_q & ~ack_q & ~AON_MASK;
        gnt  = '0;
        for (int k = NUM_PD - 1; k >= 0; k--)
            if (pend[(int'(rr_q) + k) % NUM_PD]) gnt = PW'((int'(rr_q) + k) % NUM_PD);
        tgt_g   = pcs_vol_scale[int'(gnt)*VS_W +: VS_W];
        lvl_nxt = lvl_q[ch_q] < tgt_q ? lvl_q[ch_q] + 1'b1 : lvl_q[ch_q] - 1'b1;
    end

    // Ramp engine FSM with all per-channel level, valid and acknowledge state
    always_ff @(posedge aopd_clk_32k or negedge aopd_rtc_rstn) begin
        if (!aopd_rtc_rstn) begin
            st_q   <= IDLE;
            rr_q   <= '0;
            ch_q   <= '0;
            tgt_q  <= '0;
            step_q <= '0;
            set_q  <= '0;
            ack_q  <= '0;
            for (int i = 0; i < NUM_PD; i++) begin
                lvl_q[i] <= AON_MASK[i] ? '1 : VS_W'(RST_VS);
                on_q[i]  <= AON_MASK[i] || (RST_VS != 0);
            end
        end else begin
            for (int i = 0; i < NUM_PD; i++)
                if (AON_MASK[i]) ack_q[i] <= req_s_q[i];
            case (st_q)
                IDLE: if (|pend) begin
                    ch_q  <= gnt;
                    tgt_q <= tgt_g;
                    if (tgt_g == lvl_q[gnt]) begin
                        st_q       <= ACK;
                        ack_q[gnt] <= 1'b1;
                        on_q[gnt]  <= lvl_q[gnt] != '0;
                    end else begin
                        st_q      <= RAMP;
                        step_q    <= '0;
                        on_q[gnt] <= 1'b0;
                    end
                end
                RAMP: if (!voltage_unstable[ch_q]) begin
                    if (step_q == SW'(STEP_CYC - 1)) begin
                        step_q      <= '0;
                        lvl_q[ch_q] <= lvl_nxt;
                        if (lvl_nxt == tgt_q) begin
                            st_q  <= SETTLE;
                            set_q <= '0;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                SETTLE: if (voltage_unstable[ch_q]) begin
                    set_q <= '0;
                end else if (set_q == CW'(SETTLE_CYC - 1)) begin
                    st_q        <= ACK;
                    ack_q[ch_q] <= 1'b1;
                    on_q[ch_q]  <= lvl_q[ch_q] != '0;
                end else begin
                    set_q <= set_q + 1'b1;
                end
                ACK: if (!req_s_q[ch_q]) begin
                    ack_q[ch_q] <= 1'b0;
                    rr_q        <= ch_q == PW'(NUM_PD - 1) ? '0 : ch_q + 1'b1;
                    st_q        <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ae350_dvs_ctrl.sv
// tb_ae350_dvs_ctrl: random request traffic checked every cycle against a transaction-level model
module tb_ae350_dvs_ctrl;
    localparam int N = 7, W = 3, RV = 4, SC = 4, STC = 8;
    localparam logic [N-1:0] AON = 7'b1;

    logic           clk = 1'b0, rstn = 1'b0;
    logic [N-1:0]   req = '0, unst = '0;
    logic [N*W-1:0] scale = '0;
    logic [N-1:0]   ack, von;
    logic [N*W-1:0] lvl;
    logic           busy;

    ae350_dvs_ctrl #(.NUM_PD(N), .VS_W(W), .RST_VS(RV), .STEP_CYC(SC), .SETTLE_CYC(STC), .AON_MASK(AON)) dut (
        .aopd_clk_32k(clk), .aopd_rtc_rstn(rstn), .pcs_vol_scale_req(req), .pcs_vol_scale(scale),
        .voltage_unstable(unst), .pcs_vol_scale_ack(ack), .pd_vol_on(von), .pd_vol_level(lvl), .dvs_busy(busy));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Model: phase 0 idle, 1 ramping, 2 settling, 3 acknowledged; ramp progress is a count of stable cycles
    bit [N-1:0] m_s1, m_s2, m_ack, m_on, m_rs;
    int m_lvl[N];
    int m_ph, m_ch, m_tgt, m_start, m_work, m_set, m_rr, m_g, m_dist;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] m_lvl_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_lvl[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_ack = '0; m_ph = 0; m_rr = 0; m_ch = 0; m_work = 0; m_set = 0;
        for (int i = 0; i < N; i++) begin
            m_lvl[i] = AON[i] ? (1 << W) - 1 : RV;
            m_on[i]  = AON[i] || RV != 0;
        end
    endtask

    task automatic model_step();
        m_rs = m_s2; m_s2 = m_s1; m_s1 = req;
        case (m_ph)
            0: begin
                m_g = -1;
                for (int k = 0; k < N; k++)
                    if (m_g < 0 && m_rs[(m_rr + k) % N] && !m_ack[(m_rr + k) % N] && !AON[(m_rr + k) % N])
                        m_g = (m_rr + k) % N;
                if (m_g >= 0) begin
                    m_ch = m_g; m_tgt = int'(scale[m_g*W +: W]); m_start = m_lvl[m_g]; m_work = 0;
                    if (m_tgt == m_start) begin
                        m_ph = 3; m_ack[m_ch] = 1'b1; m_on[m_ch] = m_start != 0;
                    end else begin
                        m_ph = 1; m_on[m_ch] = 1'b0;
                    end
                end
            end
            1: if (!unst[m_ch]) begin
                m_work++;
                m_dist = m_tgt > m_start ? m_tgt - m_start : m_start - m_tgt;
                m_lvl[m_ch] = m_start + (m_tgt > m_start ? 1 : -1) * (m_work / SC);
                if (m_work == m_dist * SC) begin m_ph = 2; m_set = 0; end
            end
            2: if (unst[m_ch]) m_set = 0;
               else begin
                   m_set++;
                   if (m_set == STC) begin m_ph = 3; m_ack[m_ch] = 1'b1; m_on[m_ch] = m_lvl[m_ch] != 0; end
               end
            default: if (!m_rs[m_ch]) begin m_ack[m_ch] = 1'b0; m_rr = (m_ch + 1) % N; m_ph = 0; end
        endcase
        for (int i = 0; i < N; i++) if (AON[i]) m_ack[i] = m_rs[i];
    endtask

    task automatic compare_all();
        chk("ack", ack, m_ack);
        chk("vol_on", von, m_on);
        chk("level", lvl, m_lvl_vec());
        chk("busy", busy, m_ph != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ack"}, ack, 7'h00);
        chk({tag, "_on"}, von, 7'h7F);
        chk({tag, "_level"}, lvl, 21'o4444447);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int n, t;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        compare_all();
        rstn = 1'b1;
        cycle();
        // Directed: ch2 4->6 with a clean regulator
        scale[2*W +: W] = 3'd6;
        req[2] = 1'b1;
        n = 0;
        while (!ack[2] && n < 100) begin cycle(); n++; end
        chk("ch2_ack_latency", n, 19);
        chk("ch2_level", lvl[2*W +: W], 3'd6);
        req[2] = 1'b0;
        n = 0;
        while (ack[2] && n < 20) begin cycle(); n++; end
        chk("ch2_ack_drop", n, 3);
        // Random traffic: well-behaved requesters with occasional early withdrawal and regulator glitches
        for (int c = 0; c < 4000; c++) begin
            cycle();
            for (int i = 1; i < N; i++) begin
                if (!req[i] && !ack[i] && $urandom_range(7) == 0) begin
                    scale[i*W +: W] = W'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && (ack[i] ? $urandom_range(1) == 0 : $urandom_range(63) == 0)) begin
                    req[i] = 1'b0;
                end
            end
            if ($urandom_range(3) == 0) req[0] = ~req[0];
            for (int i = 0; i < N; i++) unst[i] = $urandom_range(9) == 0;
        end
        // Drain, then reset in the middle of a ch6 ramp
        req = '0; unst = '0;
        n = 0;
        while ((busy || ack != '0) && n < 500) begin cycle(); n++; end
        chk("drain_idle", busy || ack != '0, 1'b0);
        t = (m_lvl[6] + 3) % 8;
        scale[6*W +: W] = W'(t);
        req[6] = 1'b1;
        n = 0;
        while (!busy && n < 20) begin cycle(); n++; end
        chk("ch6_busy", busy, 1'b1);
        repeat (5) cycle();
        #2 rstn = 1'b0;
        model_reset();
        #1 check_reset_values("midramp_reset");
        compare_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
